// File: rtl/mult_reservation_station.sv
// Multiplier reservation station: holds dispatched ops until both operands arrive, issues lowest ready slot.
// Issue outputs come combinationally from registered state; a slot is consumed on readyRS_o & ~stallRS_i.
module mult_reservation_station #(
    parameter int ROBsize    = 32,
    parameter int ROBsizeLog = $clog2(ROBsize + 1),
    parameter int ENTRIES    = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  dispatchValid_i,
    input  logic [9:0]            dispatchCommands_i,
    input  logic [ROBsizeLog-1:0] dispatchTag_i,
    input  logic [63:0]           dispatchVal1_i,
    input  logic [63:0]           dispatchVal2_i,
    input  logic                  dispatchRdy1_i,
    input  logic                  dispatchRdy2_i,
    input  logic [ROBsizeLog-1:0] dispatchSrc1Tag_i,
    input  logic [ROBsizeLog-1:0] dispatchSrc2Tag_i,
    output logic                  full_o,
    input  logic                  cdbValid_i,
    input  logic [ROBsizeLog-1:0] cdbTag_i,
    input  logic [63:0]           cdbVal_i,
    output logic [63:0]           reservationStationVal1_o,
    output logic [63:0]           reservationStationVal2_o,
    output logic [9:0]            reservationStationCommands_o,
    output logic [ROBsizeLog-1:0] reservationStationTag_o,
    output logic                  readyRS_o,
    input  logic                  stallRS_i
);
    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0]    busy_q, busy_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic [9:0]            cmd_q  [ENTRIES];
    logic [9:0]            cmd_d  [ENTRIES];
    logic [ROBsizeLog-1:0] tag_q  [ENTRIES];
    logic [ROBsizeLog-1:0] tag_d  [ENTRIES];
    logic [ROBsizeLog-1:0] src1_q [ENTRIES];
    logic [ROBsizeLog-1:0] src1_d [ENTRIES];
    logic [ROBsizeLog-1:0] src2_q [ENTRIES];
    logic [ROBsizeLog-1:0] src2_d [ENTRIES];
    logic [63:0]           val1_q [ENTRIES];
    logic [63:0]           val1_d [ENTRIES];
    logic [63:0]           val2_q [ENTRIES];
    logic [63:0]           val2_d [ENTRIES];

    logic [IW-1:0] free_idx, sel_idx;
    logic          sel_found, dispatch_acc, issue;

    // Descending scan so the lowest matching index is what remains.
    always_comb begin
        free_idx  = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_idx = IW'(i);
            end
            if (busy_q[i] && rdy1_q[i] && rdy2_q[i]) begin
                sel_idx   = IW'(i);
                sel_found = 1'b1;
            end
        end
    end

    assign full_o       = &busy_q;
    assign readyRS_o    = sel_found;
    assign dispatch_acc = dispatchValid_i & ~full_o & ~flush_i;
    assign issue        = sel_found & ~stallRS_i;

    always_comb begin
        reservationStationVal1_o     = '0;
        reservationStationVal2_o     = '0;
        reservationStationCommands_o = '0;
        reservationStationTag_o      = '0;
        if (sel_found) begin
            reservationStationVal1_o     = val1_q[sel_idx];
            reservationStationVal2_o     = val2_q[sel_idx];
            reservationStationCommands_o = cmd_q[sel_idx];
            reservationStationTag_o      = tag_q[sel_idx];
        end
    end

    always_comb begin
        busy_d = busy_q;
        rdy1_d = rdy1_q;
        rdy2_d = rdy2_q;
        cmd_d  = cmd_q;
        tag_d  = tag_q;
        src1_d = src1_q;
        src2_d = src2_q;
        val1_d = val1_q;
        val2_d = val2_q;

        if (cdbValid_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (busy_q[i] && !rdy1_q[i] && src1_q[i] == cdbTag_i) begin
                    rdy1_d[i] = 1'b1;
                    val1_d[i] = cdbVal_i;
                end
                if (busy_q[i] && !rdy2_q[i] && src2_q[i] == cdbTag_i) begin
                    rdy2_d[i] = 1'b1;
                    val2_d[i] = cdbVal_i;
                end
            end
        end

        if (issue) begin
            busy_d[sel_idx] = 1'b0;
        end

        // The free slot is never the issuing slot, so dispatch and issue never collide.
        if (dispatch_acc) begin
            busy_d[free_idx] = 1'b1;
            cmd_d[free_idx]  = dispatchCommands_i;
            tag_d[free_idx]  = dispatchTag_i;
            src1_d[free_idx] = dispatchSrc1Tag_i;
            src2_d[free_idx] = dispatchSrc2Tag_i;
            rdy1_d[free_idx] = dispatchRdy1_i | (cdbValid_i && dispatchSrc1Tag_i == cdbTag_i);
            rdy2_d[free_idx] = dispatchRdy2_i | (cdbValid_i && dispatchSrc2Tag_i == cdbTag_i);
            val1_d[free_idx] = dispatchRdy1_i ? dispatchVal1_i : cdbVal_i;
            val2_d[free_idx] = dispatchRdy2_i ? dispatchVal2_i : cdbVal_i;
        end

        if (flush_i) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q <= '0;
            rdy1_q <= '0;
            rdy2_q <= '0;
        end else begin
            busy_q <= busy_d;
            rdy1_q <= rdy1_d;
            rdy2_q <= rdy2_d;
        end
    end

    always_ff @(posedge clk_i) begin
        cmd_q  <= cmd_d;
        tag_q  <= tag_d;
        src1_q <= src1_d;
        src2_q <= src2_d;
        val1_q <= val1_d;
        val2_q <= val2_d;
    end

endmodule

// File: tb/tb_mult_reservation_station.sv
// Directed bench for mult_reservation_station with hand-computed expectations.
module tb_mult_reservation_station;
    localparam int RL = 6;

    logic          clk_i = 1'b0;
    logic          reset_i, flush_i, dispatchValid_i;
    logic [9:0]    dispatchCommands_i;
    logic [RL-1:0] dispatchTag_i, dispatchSrc1Tag_i, dispatchSrc2Tag_i;
    logic [63:0]   dispatchVal1_i, dispatchVal2_i;
    logic          dispatchRdy1_i, dispatchRdy2_i;
    logic          full_o;
    logic          cdbValid_i;
    logic [RL-1:0] cdbTag_i;
    logic [63:0]   cdbVal_i;
    logic [63:0]   reservationStationVal1_o, reservationStationVal2_o;
    logic [9:0]    reservationStationCommands_o;
    logic [RL-1:0] reservationStationTag_o;
    logic          readyRS_o;
    logic          stallRS_i;

    int passes = 0;
    int total  = 0;

    mult_reservation_station dut (
        .clk_i                       (clk_i),
        .reset_i                     (reset_i),
        .flush_i                     (flush_i),
        .dispatchValid_i             (dispatchValid_i),
        .dispatchCommands_i          (dispatchCommands_i),
        .dispatchTag_i               (dispatchTag_i),
        .dispatchVal1_i              (dispatchVal1_i),
        .dispatchVal2_i              (dispatchVal2_i),
        .dispatchRdy1_i              (dispatchRdy1_i),
        .dispatchRdy2_i              (dispatchRdy2_i),
        .dispatchSrc1Tag_i           (dispatchSrc1Tag_i),
        .dispatchSrc2Tag_i           (dispatchSrc2Tag_i),
        .full_o                      (full_o),
        .cdbValid_i                  (cdbValid_i),
        .cdbTag_i                    (cdbTag_i),
        .cdbVal_i                    (cdbVal_i),
        .reservationStationVal1_o    (reservationStationVal1_o),
        .reservationStationVal2_o    (reservationStationVal2_o),
        .reservationStationCommands_o(reservationStationCommands_o),
        .reservationStationTag_o     (reservationStationTag_o),
        .readyRS_o                   (readyRS_o),
        .stallRS_i                   (stallRS_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [RL-1:0] tag, input logic [63:0] v1, input logic [63:0] v2,
                         input logic r1, input logic r2,
                         input logic [RL-1:0] s1, input logic [RL-1:0] s2);
        dispatchValid_i    = 1'b1;
        dispatchCommands_i = 10'(tag) + 10'h100;
        dispatchTag_i      = tag;
        dispatchVal1_i     = v1;
        dispatchVal2_i     = v2;
        dispatchRdy1_i     = r1;
        dispatchRdy2_i     = r2;
        dispatchSrc1Tag_i  = s1;
        dispatchSrc2Tag_i  = s2;
    endtask

    initial begin
        reset_i = 1'b1; flush_i = 1'b0; dispatchValid_i = 1'b0; dispatchCommands_i = '0;
        dispatchTag_i = '0; dispatchSrc1Tag_i = '0; dispatchSrc2Tag_i = '0;
        dispatchVal1_i = '0; dispatchVal2_i = '0; dispatchRdy1_i = 1'b0; dispatchRdy2_i = 1'b0;
        cdbValid_i = 1'b0; cdbTag_i = '0; cdbVal_i = '0; stallRS_i = 1'b0;
        tick(); tick();
        reset_i = 1'b0;
        check("rst_full", 64'(full_o), 64'd0);
        check("rst_ready", 64'(readyRS_o), 64'd0);
        check("rst_val1", reservationStationVal1_o, 64'd0);
        check("rst_val2", reservationStationVal2_o, 64'd0);
        check("rst_tag", 64'(reservationStationTag_o), 64'd0);
        check("rst_cmd", 64'(reservationStationCommands_o), 64'd0);

        // Both operands ready: selectable next cycle, consumed the cycle after.
        drive(6'd5, 64'd3, 64'd7, 1'b1, 1'b1, 6'd0, 6'd0);
        tick();
        dispatchValid_i = 1'b0;
        check("basic_ready", 64'(readyRS_o), 64'd1);
        check("basic_val1", reservationStationVal1_o, 64'd3);
        check("basic_val2", reservationStationVal2_o, 64'd7);
        check("basic_tag", 64'(reservationStationTag_o), 64'd5);
        check("basic_cmd", 64'(reservationStationCommands_o), 64'h105);
        tick();
        check("basic_consumed", 64'(readyRS_o), 64'd0);
        check("basic_zero_val1", reservationStationVal1_o, 64'd0);

        // Wakeup via CDB; a non-matching tag first must not wake the slot.
        drive(6'd2, 64'd1, 64'd0, 1'b1, 1'b0, 6'd0, 6'd9);
        tick();
        dispatchValid_i = 1'b0;
        check("wake_wait", 64'(readyRS_o), 64'd0);
        cdbValid_i = 1'b1; cdbTag_i = 6'd8; cdbVal_i = 64'hFF;
        tick();
        check("wake_wrong_tag", 64'(readyRS_o), 64'd0);
        cdbTag_i = 6'd9; cdbVal_i = 64'h10;
        tick();
        cdbValid_i = 1'b0;
        check("wake_ready", 64'(readyRS_o), 64'd1);
        check("wake_val2", reservationStationVal2_o, 64'h10);
        check("wake_val1", reservationStationVal1_o, 64'd1);
        check("wake_tag", 64'(reservationStationTag_o), 64'd2);
        tick();
        check("wake_consumed", 64'(readyRS_o), 64'd0);

        // Fill under stall, fifth dispatch rejected until one slot issues.
        stallRS_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(6'(10 + i), 64'(i), 64'(i), 1'b1, 1'b1, 6'd0, 6'd0);
            tick();
        end
        check("fill_full", 64'(full_o), 64'd1);
        check("fill_sel", 64'(reservationStationTag_o), 64'd10);
        drive(6'd14, 64'h14, 64'h14, 1'b1, 1'b1, 6'd0, 6'd0);
        tick();
        check("fifth_ignored_full", 64'(full_o), 64'd1);
        check("fifth_ignored_sel", 64'(reservationStationTag_o), 64'd10);
        stallRS_i = 1'b0;
        tick();
        check("issue_frees", 64'(full_o), 64'd0);
        check("issue_next_sel", 64'(reservationStationTag_o), 64'd11);
        stallRS_i = 1'b1;
        tick();
        dispatchValid_i = 1'b0;
        check("fifth_accepted_full", 64'(full_o), 64'd1);
        check("fifth_accepted_sel", 64'(reservationStationTag_o), 64'd14);
        check("fifth_accepted_val1", reservationStationVal1_o, 64'h14);
        stallRS_i = 1'b0;
        tick();
        stallRS_i = 1'b1;
        check("three_busy_full", 64'(full_o), 64'd0);
        check("three_busy_sel", 64'(reservationStationTag_o), 64'd11);

        // Flush beats a simultaneous dispatch.
        flush_i = 1'b1;
        drive(6'd20, 64'd1, 64'd1, 1'b1, 1'b1, 6'd0, 6'd0);
        tick();
        flush_i = 1'b0; dispatchValid_i = 1'b0;
        check("flush_ready", 64'(readyRS_o), 64'd0);
        check("flush_full", 64'(full_o), 64'd0);
        check("flush_val1", reservationStationVal1_o, 64'd0);
        stallRS_i = 1'b0;

        // Same-cycle dispatch and CDB broadcast of the missing operand.
        drive(6'd3, 64'd0, 64'h22, 1'b0, 1'b1, 6'd4, 6'd0);
        cdbValid_i = 1'b1; cdbTag_i = 6'd4; cdbVal_i = 64'hAB;
        tick();
        dispatchValid_i = 1'b0; cdbValid_i = 1'b0;
        check("bypass_ready", 64'(readyRS_o), 64'd1);
        check("bypass_val1", reservationStationVal1_o, 64'hAB);
        check("bypass_val2", reservationStationVal2_o, 64'h22);
        tick();
        check("bypass_consumed", 64'(readyRS_o), 64'd0);

        // Stall holds the slot for three cycles; release consumes it in one.
        stallRS_i = 1'b1;
        drive(6'd7, 64'h55, 64'h66, 1'b1, 1'b1, 6'd0, 6'd0);
        tick();
        dispatchValid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_ready", 64'(readyRS_o), 64'd1);
            check("stall_val1", reservationStationVal1_o, 64'h55);
            check("stall_tag", 64'(reservationStationTag_o), 64'd7);
            tick();
        end
        stallRS_i = 1'b0;
        tick();
        check("stall_release", 64'(readyRS_o), 64'd0);

        // Reset mid-operation wins over flush and dispatch.
        stallRS_i = 1'b1;
        drive(6'd1, 64'd9, 64'd9, 1'b1, 1'b1, 6'd0, 6'd0);
        tick();
        check("pre_reset_ready", 64'(readyRS_o), 64'd1);
        reset_i = 1'b1; flush_i = 1'b1;
        tick();
        reset_i = 1'b0; flush_i = 1'b0; dispatchValid_i = 1'b0;
        check("midreset_ready", 64'(readyRS_o), 64'd0);
        check("midreset_full", 64'(full_o), 64'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
